// File: rtl/c499_ecc_pkg.sv
// Shared widths and H-matrix description for the c499-style SEC data corrector.
package c499_ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;

  // Upper nibble of each column, indexed by group g = k/4.
  localparam logic [7:0][3:0] U_TAB = {4'hE, 4'hD, 4'hB, 4'h7,
                                       4'h8, 4'h4, 4'h2, 4'h1};

  function automatic logic [CHK_W-1:0] h_col(input int k);
    logic [2:0] g;
    logic [1:0] j;
    logic [3:0] lane;
    g    = 3'(k / 4);
    j    = 2'(k % 4);
    lane = 4'b0001 << j;
    return {U_TAB[g], lane};
  endfunction

endpackage

// File: rtl/c499_syndrome_gen.sv
// Combinational syndrome generator: parity over H columns XOR gated check bits.
module c499_syndrome_gen
  import c499_ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  input  logic [CHK_W-1:0]  chk_in,
  input  logic              en,
  output logic [CHK_W-1:0]  syn
);

  logic [CHK_W-1:0] par;

  always_comb begin
    par = '0;
    for (int k = 0; k < DATA_W; k++) begin
      par = par ^ (h_col(k) & {CHK_W{data_in[k]}});
    end
  end

  // en=0 zeroes the check bits only; the decode downstream still acts on par.
  assign syn = par ^ (chk_in & {CHK_W{en}});

endmodule

// File: rtl/c499_ecc_corrector.sv
// Registered 32-bit single-error corrector: column match flips one data bit.
module c499_ecc_corrector
  import c499_ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CHK_W-1:0]  chk_in,
  input  logic              en,
  output logic [DATA_W-1:0] data_out,
  output logic              corr,
  output logic              err
);

  logic [CHK_W-1:0]  syn;
  logic [DATA_W-1:0] flip;

  c499_syndrome_gen u_syn (
    .data_in (data_in),
    .chk_in  (chk_in),
    .en      (en),
    .syn     (syn)
  );

  // Columns are distinct, so at most one bit of flip is ever set.
  always_comb begin
    flip = '0;
    for (int k = 0; k < DATA_W; k++) begin
      flip[k] = (syn == h_col(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      corr     <= 1'b0;
      err      <= 1'b0;
    end else begin
      data_out <= data_in ^ flip;
      corr     <= |flip;
      err      <= |syn;
    end
  end

endmodule

// File: tb/tb_c499_ecc_corrector.sv
// Self-checking bench: directed vector table, reset sequences and random traffic via a scoreboard.
module tb_c499_ecc_corrector;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  chk;
    logic        en;
    logic [31:0] exp_data;
    logic        exp_corr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        corr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  chk_in = '0;
  logic        en = 1'b0;
  logic [31:0] data_out;
  logic        corr;
  logic        err;

  int total = 0;
  int bad   = 0;

  exp_t sb_q[$];
  vec_t tab[10];
  logic [3:0] um[8];

  always #5 clk = ~clk;

  c499_ecc_corrector dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .chk_in   (chk_in),
    .en       (en),
    .data_out (data_out),
    .corr     (corr),
    .err      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference parity: lane parities plus parities of groups selected by U bits.
  function automatic logic [7:0] m_parity(input logic [31:0] d);
    logic [3:0] lane;
    logic [7:0] grp;
    logic [3:0] hi;
    lane = '0;
    hi   = '0;
    for (int g = 0; g < 8; g++) begin
      grp[g] = ^d[4*g +: 4];
      lane   = lane ^ d[4*g +: 4];
    end
    for (int b = 0; b < 4; b++)
      for (int g = 0; g < 8; g++)
        if (um[g][b]) hi[b] = hi[b] ^ grp[g];
    return {hi, lane};
  endfunction

  // Reference decode: one-hot low nibble picks the lane, high nibble looked up in U.
  function automatic int m_decode(input logic [7:0] s);
    int j;
    j = -1;
    if ($countones(s[3:0]) != 1) return -1;
    for (int i = 0; i < 4; i++) if (s[i]) j = i;
    for (int g = 0; g < 8; g++) if (um[g] == s[7:4]) return 4*g + j;
    return -1;
  endfunction

  function automatic exp_t m_expect(input logic [31:0] d, input logic [7:0] c, input logic e);
    exp_t r;
    logic [7:0] s;
    int k;
    s = m_parity(d) ^ (e ? c : 8'h00);
    k = m_decode(s);
    r.data = d;
    r.corr = 1'b0;
    if (k >= 0) begin
      r.data[k] = ~r.data[k];
      r.corr    = 1'b1;
    end
    r.err = (s != 8'h00);
    return r;
  endfunction

  task automatic drive(input logic [31:0] d, input logic [7:0] c, input logic e, input exp_t x);
    @(negedge clk);
    data_in = d;
    chk_in  = c;
    en      = e;
    sb_q.push_back(x);
  endtask

  // Each posedge consumes exactly one entry, so a bubble or extra delay shows up as a mismatch.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (!rst && sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("data_out", data_out, x.data);
      check("corr", {31'b0, corr}, {31'b0, x.corr});
      check("err", {31'b0, err}, {31'b0, x.err});
    end
  end

  initial begin
    exp_t x;
    logic [31:0] d;
    logic [7:0]  c;
    logic        e;

    um[0] = 4'h1; um[1] = 4'h2; um[2] = 4'h4; um[3] = 4'h8;
    um[4] = 4'h7; um[5] = 4'hB; um[6] = 4'hD; um[7] = 4'hE;

    tab[0] = '{32'h00000001, 8'h11, 1'b1, 32'h00000001, 1'b0, 1'b0};
    tab[1] = '{32'h00000000, 8'h00, 1'b1, 32'h00000000, 1'b0, 1'b0};
    tab[2] = '{32'h80000000, 8'hE8, 1'b1, 32'h80000000, 1'b0, 1'b0};
    tab[3] = '{32'h00000000, 8'h11, 1'b1, 32'h00000001, 1'b1, 1'b1};
    tab[4] = '{32'h00000000, 8'hE8, 1'b1, 32'h80000000, 1'b1, 1'b1};
    tab[5] = '{32'h00000000, 8'h01, 1'b1, 32'h00000000, 1'b0, 1'b1};
    tab[6] = '{32'h00000003, 8'h00, 1'b1, 32'h00000003, 1'b0, 1'b1};
    tab[7] = '{32'h00000001, 8'h11, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tab[8] = '{32'h00000000, 8'h71, 1'b1, 32'h00010000, 1'b1, 1'b1};
    tab[9] = '{32'h00000010, 8'h21, 1'b1, 32'h00000010, 1'b0, 1'b0};

    // Reset asserted with live inputs: outputs clear without a clock edge.
    #1;
    data_in = 32'hDEADBEEF; chk_in = 8'h5A; en = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_data", data_out, 32'h0);
    check("rst_flags", {30'b0, corr, err}, 32'h0);
    @(posedge clk); #1;
    check("rst_hold_data", data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_hold", {data_out[29:0], corr, err}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      x.data = tab[i].exp_data;
      x.corr = tab[i].exp_corr;
      x.err  = tab[i].exp_err;
      drive(tab[i].data, tab[i].chk, tab[i].en, x);
    end

    // Reset mid-stream: the word in flight is dropped.
    drive(32'h00000000, 8'h11, 1'b1, x);
    #2;
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_flags", {30'b0, corr, err}, 32'h0);
    @(posedge clk); #1;
    check("mid_rst_edge", {data_out[29:0], corr, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Random back-to-back traffic: clean, single data/check errors, double errors, en=0.
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      e = ($urandom_range(0, 7) != 0);
      c = m_parity(d);
      case ($urandom_range(0, 3))
        0: ;
        1: d[$urandom_range(0, 31)] ^= 1'b1;
        2: c[$urandom_range(0, 7)] ^= 1'b1;
        default: begin
          d[$urandom_range(0, 15)]  ^= 1'b1;
          d[$urandom_range(16, 31)] ^= 1'b1;
        end
      endcase
      drive(d, c, e, m_expect(d, c, e));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
